uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Buffered transmit controller between the memory mapper's device #1 port and the UART. Core stores to the TX address push bytes into an internal FIFO instead of stalling on the UART's busy bit. A drain state machine polls the UART and issues one write per free transmitter. Core reads of the RX address pass through to the UART unchanged.

## Interface
- `FIFO_DEPTH`, 16: FIFO entries; power of two, at least 2.
- `TX_ADDR`, 32'h00010000: TX data / TX-ready address, on both the core side and the UART side.
- `RX_ADDR`, 32'h00010004: RX data address, forwarded to the UART.
- `STAT_ADDR`, 32'h00010008: status register address; see Configuration.
- `clock` in 1: single clock domain, rising edge.
- `reset` in 1: synchronous, active-high.
- `bus_rw_address` in 32: device #1 address from the memory mapper.
- `bus_wdata` in 8: write data, low byte.
- `bus_write_request` in 1: write strobe.
- `bus_rdata` out 32: read data, valid the cycle after the address.
- `uart_rw_address` out 32: address to the UART.
- `uart_wdata` out 8: byte to the UART.
- `uart_write_request` out 1: write strobe to the UART.
- `uart_rdata` in 32: UART registered read data. Bit 0 at TX_ADDR means the transmitter is idle.
- `tx_fifo_empty` out 1: FIFO holds no bytes.

## Operation
- **Reset values**
  - FIFO pointers and count are 0; `tx_fifo_empty`=1.
  - `bus_rdata`=0, `uart_write_request`=0, `uart_wdata`=0, `uart_rw_address`=0.
  - State is IDLE; overflow flag is 0.
- **Push**
  - Condition: `bus_write_request`=1 and `bus_rw_address`==TX_ADDR.
  - If not full, `bus_wdata` is written at the write pointer; the pointer wraps modulo FIFO_DEPTH.
  - If full, the byte is dropped and the overflow flag is set.
  - A core write to TX_ADDR is never forwarded to the UART.
- **Core reads**
  - TX_ADDR returns {31'b0, !full}. This is registered, so it appears the next cycle.
  - RX_ADDR returns `uart_rdata` (next cycle, combinational mux on the registered previous address).
  - STAT_ADDR returns the status word (see Configuration).
  - Any other address returns 0.
- **UART port ownership**
  - When `bus_rw_address`==RX_ADDR, the core owns the UART port: `uart_rw_address`=RX_ADDR, `uart_write_request`=0, and the FSM holds its state.
  - Otherwise the FSM drives the port. With nothing to drive, `uart_rw_address`=0.
- **Drain FSM**
  - IDLE: if count>0, go to POLL.
  - POLL: drive `uart_rw_address`=TX_ADDR with no write. If the FSM owned the port this cycle, go to CHECK; else stay.
  - CHECK: if `uart_rdata[0]`=1, go to SEND; else go to POLL.
  - SEND: drive `uart_rw_address`=TX_ADDR, `uart_wdata`=FIFO head, `uart_write_request`=1. If the FSM owned the port, pop the head and go to GUARD; else stay (no pop).
  - GUARD: one idle cycle so the UART busy counter loads, then go to IDLE.
- **Count rules**
  - Push and pop in the same cycle leave count unchanged.
  - A push into a full FIFO on a pop cycle is accepted, since the pop frees the slot that edge.
  - Count width is clog2(FIFO_DEPTH)+1.

## Timing
- Latency from push into an empty FIFO with an idle UART to `uart_write_request`=1: 4 cycles (push edge, IDLE, POLL, CHECK, then SEND).
- Back-to-back bytes are limited by the UART frame time (about 10 bit periods). The FSM overhead is 5 cycles per byte.
- All core read data is valid exactly 1 cycle after the address is presented. This matches the memory mapper's delayed select.
- A reset in any state:
  - returns the FIFO to empty and the state to IDLE;
  - clears the overflow flag;
  - deasserts `uart_write_request` in the same clock edge.
  - Bytes already queued are discarded.

## Configuration
- `UART_TX_SCHEDULER_STATUS_EN` defined:
  - STAT_ADDR reads {overflow, 23'b0, count[7:0]}, with overflow as bit 31 and count zero-extended into bits 7:0.
  - Any write to STAT_ADDR clears overflow. A write and an overflow in the same cycle leave overflow set.
- Not defined:
  - No overflow flag or status logic.
  - STAT_ADDR reads 0; writes to it are ignored.

## Test plan
- Reset, then write 0x41 to TX_ADDR with the UART idle → SEND 4 cycles later with `uart_wdata`=0x41; `tx_fifo_empty` back to 1 after the pop.
- Write 0x30..0x3F (16 bytes) back-to-back → TX_ADDR read returns 0 after the 16th write. The UART receives 0x30..0x3F in order, one write per frame.
- With the FIFO full, write 0x99 → byte dropped, STAT_ADDR bit 31=1. A write to STAT_ADDR clears it (STATUS_EN build); a non-STATUS_EN build reads 0.
- Hold `bus_rw_address`=RX_ADDR during POLL and during SEND → `uart_rw_address`=RX_ADDR, no UART write, no pop. SEND completes on the cycle after release. `bus_rdata` equals the UART RX byte one cycle after the address.
- Push 3 bytes, assert `reset` while in SEND → `uart_write_request`=0 next edge, count=0, `tx_fifo_empty`=1, no further UART writes.
- Push in the same cycle as a pop at count=FIFO_DEPTH → count stays FIFO_DEPTH, no overflow, byte order preserved.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Core-side (memory mapper device #1) and UART-side signals of the TX scheduler.
// Strobes (bus_write_request, uart_write_request) are single-cycle with no ready; flow control is by polling TX_ADDR bit 0, and all read data returns one cycle after its address.
interface uart_tx_scheduler_if;
  logic [31:0] bus_rw_address;
  logic [7:0]  bus_wdata;
  logic        bus_write_request;
  logic [31:0] bus_rdata;
  logic [31:0] uart_rw_address;
  logic [7:0]  uart_wdata;
  logic        uart_write_request;
  logic [31:0] uart_rdata;
  logic        tx_fifo_empty;

  modport slave (
    input  bus_rw_address, bus_wdata, bus_write_request, uart_rdata,
    output bus_rdata, uart_rw_address, uart_wdata, uart_write_request, tx_fifo_empty
  );

  modport master (
    output bus_rw_address, bus_wdata, bus_write_request, uart_rdata,
    input  bus_rdata, uart_rw_address, uart_wdata, uart_write_request, tx_fifo_empty
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Buffered UART transmit scheduler: core TX stores fill a FIFO, a drain FSM polls the UART and writes one byte per idle transmitter.
// Optional status register (overflow flag + count at STAT_ADDR) is built when UART_TX_SCHEDULER_STATUS_EN is defined.
module uart_tx_scheduler #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] TX_ADDR    = 32'h0001_0000,
  parameter logic [31:0] RX_ADDR    = 32'h0001_0004,
  parameter logic [31:0] STAT_ADDR  = 32'h0001_0008
) (
  input  logic                          clock,
  input  logic                          reset,
  uart_tx_scheduler_if.slave            bus,
  output logic [2:0]                    dbg_state_o,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_count_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POLL  = 3'd1,
    S_CHECK = 3'd2,
    S_SEND  = 3'd3,
    S_GUARD = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic               core_owns;
  logic               push_req;
  logic               full;
  logic               pop;
  logic               push_ok;

  logic [31:0]        uart_addr;
  logic [7:0]         uart_data;
  logic               uart_wr;

  logic [31:0]        stat_word;
  logic [31:0]        rd_word_d, rd_word_q;
  logic               rx_sel_q;

  assign core_owns = (bus.bus_rw_address == RX_ADDR);
  assign push_req  = bus.bus_write_request && (bus.bus_rw_address == TX_ADDR);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop       = (state_q == S_SEND) && !core_owns;
  // A pop frees the head slot on the same edge, so a push into a full FIFO is still accepted.
  assign push_ok   = push_req && (!full || pop);

  // ---------------- FIFO bookkeeping ----------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= bus.bus_wdata;
  end

  // ---------------- Drain FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!core_owns && (count_q != '0)) state_d = S_POLL;
      S_POLL:  if (!core_owns) state_d = S_CHECK;
      // The status bit was captured from the previous POLL cycle, so a core RX access now cannot corrupt it.
      S_CHECK: state_d = bus.uart_rdata[0] ? S_SEND : S_POLL;
      S_SEND:  if (!core_owns) state_d = S_GUARD;
      S_GUARD: if (!core_owns) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    uart_addr = '0;
    uart_data = '0;
    uart_wr   = 1'b0;
    if (core_owns) begin
      uart_addr = RX_ADDR;
    end else if (state_q == S_POLL) begin
      uart_addr = TX_ADDR;
    end else if (state_q == S_SEND) begin
      uart_addr = TX_ADDR;
      uart_data = mem_q[rd_ptr_q];
      uart_wr   = 1'b1;
    end
  end

  assign bus.uart_rw_address    = uart_addr;
  assign bus.uart_wdata         = uart_data;
  assign bus.uart_write_request = uart_wr;
  assign bus.tx_fifo_empty      = (count_q == '0);

  // ---------------- Optional status register ----------------
`ifdef UART_TX_SCHEDULER_STATUS_EN
  logic       ovf_q, ovf_d;
  logic       stat_wr;
  logic [7:0] cnt8;

  assign stat_wr = bus.bus_write_request && (bus.bus_rw_address == STAT_ADDR);
  assign cnt8    = 8'(count_q);

  // A drop in the same cycle as a clearing write wins, so no overflow is ever lost.
  always_comb begin
    ovf_d = ovf_q;
    if (stat_wr) ovf_d = 1'b0;
    if (push_req && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign stat_word = {ovf_q, 23'b0, cnt8};
`else
  assign stat_word = '0;
`endif

  // ---------------- Core read path ----------------
  always_comb begin
    rd_word_d = '0;
    if (bus.bus_rw_address == TX_ADDR)        rd_word_d = {31'b0, !full};
    else if (bus.bus_rw_address == STAT_ADDR) rd_word_d = stat_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_word_q <= '0;
      rx_sel_q  <= 1'b0;
    end else begin
      rd_word_q <= rd_word_d;
      rx_sel_q  <= core_owns;
    end
  end

  // UART read data is already registered, so RX only needs the delayed select.
  assign bus.bus_rdata = rx_sel_q ? bus.uart_rdata : rd_word_q;

  assign dbg_state_o = state_q;
  assign dbg_count_o = count_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed + randomized bench for uart_tx_scheduler with a behavioural UART and an expected-byte queue.
// Expectations for STAT_ADDR follow UART_TX_SCHEDULER_STATUS_EN when it is defined.
module tb_uart_tx_scheduler;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] TX    = 32'h0001_0000;
  localparam logic [31:0] RX    = 32'h0001_0004;
  localparam logic [31:0] STAT  = 32'h0001_0008;
  localparam int          FRAME = 40;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;
  logic [4:0] dbg_count;

  int errors = 0;
  int checks = 0;
  int uart_writes = 0;
  int busy_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] exp_q[$];

  uart_tx_scheduler_if sif();

  uart_tx_scheduler #(
    .FIFO_DEPTH(DEPTH),
    .TX_ADDR(TX),
    .RX_ADDR(RX),
    .STAT_ADDR(STAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(sif),
    .dbg_state_o(dbg_state),
    .dbg_count_o(dbg_count)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural UART ----------------
  always @(posedge clock) begin
    if (sif.uart_write_request === 1'b1) busy_cnt <= FRAME;
    else if (busy_cnt > 0)               busy_cnt <= busy_cnt - 1;
    if (sif.uart_rw_address == TX)       sif.uart_rdata <= {31'b0, busy_cnt == 0};
    else if (sif.uart_rw_address == RX)  sif.uart_rdata <= {24'b0, rx_byte};
    else                                 sif.uart_rdata <= '0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (sif.bus_rw_address == RX) begin
        check("own_addr", sif.uart_rw_address, RX);
        check("own_nowr", {31'b0, sif.uart_write_request}, 32'd0);
      end
      if (sif.uart_write_request === 1'b1) begin
        uart_writes++;
        check("uart_idle_at_wr", {31'b0, busy_cnt == 0}, 32'd1);
        check("wr_addr", sif.uart_rw_address, TX);
        check("wr_pending", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("wr_data", {24'b0, sif.uart_wdata}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [7:0] data);
    sif.bus_rw_address    = addr;
    sif.bus_wdata         = data;
    sif.bus_write_request = 1'b1;
    tick();
    sif.bus_write_request = 1'b0;
    sif.bus_rw_address    = '0;
    sif.bus_wdata         = '0;
  endtask

  task automatic push(input logic [7:0] data);
    bus_write(TX, data);
    exp_q.push_back(data);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    sif.bus_rw_address = addr;
    tick();
    data = sif.bus_rdata;
    sif.bus_rw_address = '0;
  endtask

  task automatic wait_send(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (sif.uart_write_request === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_drained(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0 && sif.tx_fifo_empty === 1'b1 && busy_cnt == 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] d;
    logic        ok;
    logic [4:0]  c0;
    int          r;
    int          w0;

    sif.bus_rw_address    = '0;
    sif.bus_wdata         = '0;
    sif.bus_write_request = 1'b0;
    rx_byte = 8'($urandom_range(0, 255));

    reset = 1'b1;
    repeat (3) tick();
    check("rst_empty", {31'b0, sif.tx_fifo_empty}, 32'd1);
    check("rst_uwr", {31'b0, sif.uart_write_request}, 32'd0);
    check("rst_uaddr", sif.uart_rw_address, 32'd0);
    check("rst_uwdata", {24'b0, sif.uart_wdata}, 32'd0);
    check("rst_rdata", sif.bus_rdata, 32'd0);
    check("rst_count", {27'b0, dbg_count}, 32'd0);
    reset = 1'b0;
    tick();

    // Single byte: SEND four cycles after the push cycle.
    push(8'h41);
    tick();
    tick();
    check("lat_not_yet", {31'b0, sif.uart_write_request}, 32'd0);
    tick();
    check("lat_send", {31'b0, sif.uart_write_request}, 32'd1);
    check("lat_wdata", {24'b0, sif.uart_wdata}, 32'h41);
    tick();
    check("pop_empty", {31'b0, sif.tx_fifo_empty}, 32'd1);

    // Fill while the UART is still busy with 0x41.
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
    check("full_count", {27'b0, dbg_count}, 32'd16);
    bus_read(TX, d);
    check("tx_ready_full", d, 32'd0);

    // Overflow: dropped byte, flag visible, write to STAT clears it.
    bus_write(TX, 8'h99);
    check("ovf_count", {27'b0, dbg_count}, 32'd16);
    bus_read(STAT, d);
`ifdef UART_TX_SCHEDULER_STATUS_EN
    check("stat_ovf", d, 32'h8000_0010);
`else
    check("stat_ovf", d, 32'd0);
`endif
    bus_write(STAT, 8'h00);
    bus_read(STAT, d);
`ifdef UART_TX_SCHEDULER_STATUS_EN
    check("stat_clr", d, 32'h0000_0010);
`else
    check("stat_clr", d, 32'd0);
`endif

    // Push on the pop cycle of a full FIFO.
    wait_send(500, ok);
    check("pp_send_seen", {31'b0, ok}, 32'd1);
    bus_write(TX, 8'hA5);
    exp_q.push_back(8'hA5);
    check("pp_count", {27'b0, dbg_count}, 32'd16);
    bus_read(STAT, d);
`ifdef UART_TX_SCHEDULER_STATUS_EN
    check("pp_no_ovf", d, 32'h0000_0010);
`else
    check("pp_no_ovf", d, 32'd0);
`endif

    // Core holds RX during POLL.
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (sif.uart_rw_address == TX && sif.uart_write_request === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("poll_seen", {31'b0, ok}, 32'd1);
    c0 = dbg_count;
    sif.bus_rw_address = RX;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rxp_addr", sif.uart_rw_address, RX);
      check("rxp_nowr", {31'b0, sif.uart_write_request}, 32'd0);
      check("rxp_rdata", sif.bus_rdata, {24'b0, rx_byte});
      check("rxp_count", {27'b0, dbg_count}, {27'b0, c0});
    end
    sif.bus_rw_address = '0;

    // Core holds RX during SEND; SEND completes after release.
    wait_send(500, ok);
    check("send_seen", {31'b0, ok}, 32'd1);
    c0 = dbg_count;
    sif.bus_rw_address = RX;
    #1;
    check("rxs_nowr0", {31'b0, sif.uart_write_request}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rxs_nowr", {31'b0, sif.uart_write_request}, 32'd0);
      check("rxs_count", {27'b0, dbg_count}, {27'b0, c0});
    end
    sif.bus_rw_address = '0;
    #1;
    check("rxs_resume", {31'b0, sif.uart_write_request}, 32'd1);
    tick();
    check("rxs_pop", {27'b0, dbg_count}, {27'b0, 5'(c0 - 5'd1)});

    wait_drained(4000, ok);
    check("drain1", {31'b0, ok}, 32'd1);

    // Randomized traffic mixing pushes, RX reads and TX-ready reads.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 30 && exp_q.size() < DEPTH - 2) begin
        push(8'($urandom_range(0, 255)));
      end else if (r < 45) begin
        rx_byte = 8'($urandom_range(0, 255));
        bus_read(RX, d);
        check("rnd_rx", d, {24'b0, rx_byte});
      end else if (r < 55) begin
        bus_read(TX, d);
        check("rnd_txrdy", d, 32'd1);
      end else begin
        tick();
      end
    end
    wait_drained(4000, ok);
    check("drain2", {31'b0, ok}, 32'd1);
    check("drain2_empty", {31'b0, sif.tx_fifo_empty}, 32'd1);

    // Reset while in SEND discards the queue.
    for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)));
    wait_send(200, ok);
    check("rst_send_seen", {31'b0, ok}, 32'd1);
    reset = 1'b1;
    tick();
    check("rstm_uwr", {31'b0, sif.uart_write_request}, 32'd0);
    check("rstm_count", {27'b0, dbg_count}, 32'd0);
    check("rstm_empty", {31'b0, sif.tx_fifo_empty}, 32'd1);
    exp_q.delete();
    reset = 1'b0;
    w0 = uart_writes;
    repeat (120) tick();
    check("rstm_no_wr", uart_writes - w0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
